// File: rtl/matmul_job_scheduler_pkg.sv
// Shared types, derived constants and the descriptor check for the matmul block.
package matmul_pkg;

    localparam int ARRAY_HEIGHT = 4;
    localparam int ARRAY_WIDTH  = 32;
    localparam int DATA_WIDTH   = 16;
    localparam int BUS_WIDTH    = 256;
    localparam int ADDR_WIDTH   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH_A,
        S_FETCH_B,
        S_DRAIN,
        S_DONE,
        S_ERR
    } sched_state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // bytes per element
    function automatic int unsigned bytes_f(input int unsigned dw);
        return dw / 8;
    endfunction

    // elements per memory beat
    function automatic int unsigned epb_f(input int unsigned bw, input int unsigned dw);
        return bw / dw;
    endfunction

    // memory beats per tile row
    function automatic int unsigned bpr_f(input int unsigned aw, input int unsigned bw,
                                          input int unsigned dw);
        return ceil_div(aw, epb_f(bw, dw));
    endfunction

    // Descriptor must be non-empty and tile-aligned on m and p; also used by the results controller.
    function automatic logic dims_ok(input logic [15:0] m, input logic [15:0] n, input logic [15:0] p,
                                     input int unsigned ah, input int unsigned aw);
        return (m != 16'd0) && (n != 16'd0) && (p != 16'd0) &&
               (({16'd0, m} % ah) == 32'd0) && (({16'd0, p} % aw) == 32'd0);
    endfunction

endpackage

// File: rtl/matmul_job_scheduler_if.sv
// Job descriptor, operand read request and C write address bundle of the scheduler.
interface matmul_job_scheduler_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [15:0]           cfg_m;
    logic [15:0]           cfg_n;
    logic [15:0]           cfg_p;
    logic [ADDR_WIDTH-1:0] cfg_a;
    logic [ADDR_WIDTH-1:0] cfg_b;
    logic [ADDR_WIDTH-1:0] cfg_c;

    logic                  rd_valid;
    logic                  rd_ready;
    logic                  rd_sel;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_beats;

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // scheduler side
    modport slave (
        input  cfg_valid, cfg_m, cfg_n, cfg_p, cfg_a, cfg_b, cfg_c, rd_ready,
        output cfg_ready, rd_valid, rd_sel, rd_addr, rd_beats, wr_valid, wr_addr
    );

    // host / memory side
    modport master (
        output cfg_valid, cfg_m, cfg_n, cfg_p, cfg_a, cfg_b, cfg_c, rd_ready,
        input  cfg_ready, rd_valid, rd_sel, rd_addr, rd_beats, wr_valid, wr_addr
    );
endinterface

// File: rtl/matmul_job_scheduler_tile.sv
// tile_addr_gen: nested inner counters (c0 fastest, then c1) under a tile walk
// (tj += ARRAY_WIDTH, then ti += ARRAY_HEIGHT), plus the byte address for the
// fetch side (RESULT=0: k-step of A or B) or the result side (RESULT=1: C beat).
module tile_addr_gen
    import matmul_pkg::*;
#(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int BUS_WIDTH    = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter bit RESULT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  adv,
    input  logic [15:0]           lim0,
    input  logic [15:0]           lim1,
    input  logic [15:0]           dim_m,
    input  logic [15:0]           dim_p,
    input  logic                  sel,
    input  logic [ADDR_WIDTH-1:0] base,
    output logic                  last,
    output logic [31:0]           tile_cnt,
    output logic [ADDR_WIDTH-1:0] addr
);
    localparam int unsigned BYTES = bytes_f(DATA_WIDTH);
    localparam int unsigned EPB   = epb_f(BUS_WIDTH, DATA_WIDTH);

    logic [15:0] c0, c1, ti, tj;
    logic        w0, w1, wj, wi;

    assign w0   = (c0 == lim0 - 16'd1);
    assign w1   = (c1 == lim1 - 16'd1);
    assign wj   = (({1'b0, tj} + 17'(ARRAY_WIDTH))  >= {1'b0, dim_p});
    assign wi   = (({1'b0, ti} + 17'(ARRAY_HEIGHT)) >= {1'b0, dim_m});
    assign last = w0 & w1 & wj & wi;

    // nested counter advance; each level wraps to 0 and carries into the next
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c0 <= '0; c1 <= '0; ti <= '0; tj <= '0; tile_cnt <= '0;
        end else if (clr) begin
            c0 <= '0; c1 <= '0; ti <= '0; tj <= '0; tile_cnt <= '0;
        end else if (adv) begin
            if (!w0) begin
                c0 <= c0 + 16'd1;
            end else begin
                c0 <= '0;
                if (!w1) begin
                    c1 <= c1 + 16'd1;
                end else begin
                    c1       <= '0;
                    tile_cnt <= tile_cnt + 32'd1;
                    if (!wj) begin
                        tj <= tj + 16'(ARRAY_WIDTH);
                    end else begin
                        tj <= '0;
                        ti <= wi ? 16'd0 : ti + 16'(ARRAY_HEIGHT);
                    end
                end
            end
        end
    end

    generate
        if (RESULT) begin : g_res
            logic [31:0] row, off;
            logic        unused_sel;
            assign unused_sel = sel;
            // C beat: row (ti + r), column tj + beat*EPB
            always_comb begin
                row  = 32'(ti) + 32'(c1);
                off  = row * 32'(dim_p) + 32'(tj) + 32'(c0) * EPB;
                addr = base + ADDR_WIDTH'(off * BYTES);
            end
        end else begin : g_fetch
            logic [31:0] off;
            // A^T row k at column ti, or B row k at column tj
            always_comb begin
                off  = 32'(c0) * 32'(sel ? dim_p : dim_m) + 32'(sel ? tj : ti);
                addr = base + ADDR_WIDTH'(off * BYTES);
            end
        end
    endgenerate
endmodule

// File: rtl/matmul_job_scheduler.sv
// Sequences one C = A*B job: checks the descriptor, issues A/B fragment reads
// per k-step over all output tiles, and tags result beats with C addresses.
module matmul_job_scheduler
    import matmul_pkg::*;
#(
    parameter int ARRAY_HEIGHT = matmul_pkg::ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH  = matmul_pkg::ARRAY_WIDTH,
    parameter int DATA_WIDTH   = matmul_pkg::DATA_WIDTH,
    parameter int BUS_WIDTH    = matmul_pkg::BUS_WIDTH,
    parameter int ADDR_WIDTH   = matmul_pkg::ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    matmul_job_scheduler_if.slave  bus,
    output logic                   array_start,
    input  logic                   res_valid_i,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int unsigned EPB     = epb_f(BUS_WIDTH, DATA_WIDTH);
    localparam int unsigned BPR     = bpr_f(ARRAY_WIDTH, BUS_WIDTH, DATA_WIDTH);
    localparam int unsigned A_BEATS = ceil_div(ARRAY_HEIGHT, EPB);

    sched_state_e          state, nxt;
    logic [15:0]           m_q, n_q, p_q;
    logic [ADDR_WIDTH-1:0] a_q, b_q, c_q;
    logic                  accept, f_adv, r_adv, f_last, r_last;
    logic [31:0]           f_tiles, r_tiles, total;
    logic [ADDR_WIDTH-1:0] f_addr, r_addr;
    logic                  unused_ok;

    assign accept    = (state == S_IDLE) && bus.cfg_valid;
    assign f_adv     = (state == S_FETCH_B) && bus.rd_ready;
    assign r_adv     = res_valid_i && (state inside {S_FETCH_A, S_FETCH_B, S_DRAIN});
    assign total     = 32'(m_q / 16'(ARRAY_HEIGHT)) * 32'(p_q / 16'(ARRAY_WIDTH));
    assign unused_ok = &{1'b0, f_tiles, r_last};

    assign busy         = (state != S_IDLE);
    assign bus.wr_valid = res_valid_i;
    assign bus.wr_addr  = r_addr;

    // descriptor latch on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q <= '0; n_q <= '0; p_q <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0;
        end else if (accept) begin
            m_q <= bus.cfg_m; n_q <= bus.cfg_n; p_q <= bus.cfg_p;
            a_q <= bus.cfg_a; b_q <= bus.cfg_b; c_q <= bus.cfg_c;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= nxt;
    end

    // next state and Moore/Mealy outputs
    always_comb begin
        nxt           = state;
        bus.cfg_ready = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rd_sel    = 1'b0;
        bus.rd_addr   = '0;
        bus.rd_beats  = '0;
        array_start   = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            S_IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid) nxt = S_CHECK;
            end
            S_CHECK: begin
                if (dims_ok(m_q, n_q, p_q, ARRAY_HEIGHT, ARRAY_WIDTH)) begin
                    array_start = 1'b1;
                    nxt         = S_FETCH_A;
                end else begin
                    nxt = S_ERR;
                end
            end
            S_FETCH_A: begin
                bus.rd_valid = 1'b1;
                bus.rd_addr  = f_addr;
                bus.rd_beats = 8'(A_BEATS);
                if (bus.rd_ready) nxt = S_FETCH_B;
            end
            S_FETCH_B: begin
                bus.rd_valid = 1'b1;
                bus.rd_sel   = 1'b1;
                bus.rd_addr  = f_addr;
                bus.rd_beats = 8'(BPR);
                if (bus.rd_ready) nxt = f_last ? S_DRAIN : S_FETCH_A;
            end
            S_DRAIN: begin
                if (r_tiles == total) nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    tile_addr_gen #(
        .ARRAY_HEIGHT(ARRAY_HEIGHT), .ARRAY_WIDTH(ARRAY_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .BUS_WIDTH(BUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RESULT(1'b0)
    ) u_fetch (
        .clk(clk), .reset_n(reset_n), .clr(accept), .adv(f_adv),
        .lim0(n_q), .lim1(16'd1), .dim_m(m_q), .dim_p(p_q),
        .sel(state == S_FETCH_B), .base((state == S_FETCH_B) ? b_q : a_q),
        .last(f_last), .tile_cnt(f_tiles), .addr(f_addr)
    );

    tile_addr_gen #(
        .ARRAY_HEIGHT(ARRAY_HEIGHT), .ARRAY_WIDTH(ARRAY_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .BUS_WIDTH(BUS_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RESULT(1'b1)
    ) u_res (
        .clk(clk), .reset_n(reset_n), .clr(accept), .adv(r_adv),
        .lim0(16'(BPR)), .lim1(16'(ARRAY_HEIGHT)), .dim_m(m_q), .dim_p(p_q),
        .sel(1'b0), .base(c_q),
        .last(r_last), .tile_cnt(r_tiles), .addr(r_addr)
    );
endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler: single/multi tile jobs, backpressure,
// rejected descriptors, reset mid-job and results interleaved with fetches.
`timescale 1ns/1ps
module tb_matmul_job_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic res_valid_i = 1'b0;
    logic array_start, busy, done, err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    matmul_job_scheduler_if #(.ADDR_WIDTH(32)) bus ();

    matmul_job_scheduler dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .array_start(array_start),
        .res_valid_i(res_valid_i), .busy(busy), .done(done), .err(err)
    );

    // observation queues filled on the falling edge
    logic [40:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic        err_q[$];
    int          start_cnt = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.rd_valid && bus.rd_ready) rd_q.push_back({bus.rd_sel, bus.rd_addr, bus.rd_beats});
        if (array_start) start_cnt++;
        if (bus.wr_valid) begin wr_q.push_back(bus.wr_addr); last_wr_cyc = cyc; end
        if (done) begin err_q.push_back(err); done_cyc = cyc; end
    end

    task automatic clear_mon();
        rd_q.delete(); wr_q.delete(); err_q.delete(); start_cnt = 0;
    endtask

    task automatic start_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] p,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(posedge clk); #1;
        bus.cfg_valid = 1'b1; bus.cfg_m = m; bus.cfg_n = n; bus.cfg_p = p;
        bus.cfg_a = a; bus.cfg_b = b; bus.cfg_c = c;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_beats(input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            res_valid_i = 1'b1; @(posedge clk); #1; res_valid_i = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && err_q.size() == 0; i++) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({bus.cfg_ready, bus.rd_valid, array_start, busy, done, err} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {bus.cfg_ready, bus.rd_valid, array_start, busy, done, err});
        end
        vectors++;
        if ({bus.rd_addr, bus.wr_addr, bus.rd_beats} !== 72'd0) begin
            miscompares++;
            $display("FAIL reset_data: rd_addr %h wr_addr %h beats %h want 0", bus.rd_addr, bus.wr_addr, bus.rd_beats);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_tile();
        logic [31:0] exp_wr [8] = '{32'h3000, 32'h3020, 32'h3040, 32'h3060,
                                    32'h3080, 32'h30A0, 32'h30C0, 32'h30E0};
        clear_mon(); bus.rd_ready = 1'b1;
        start_job(16'd4, 16'd1, 16'd32, 32'h1000, 32'h2000, 32'h3000);
        repeat (6) begin @(posedge clk); #1; end
        send_beats(8, 0);
        wait_done(200);
        vectors++;
        if (rd_q.size() !== 2) begin miscompares++; $display("FAIL t1_rd_count: got %0d want 2", rd_q.size()); end
        vectors++;
        if (rd_q[0] !== {1'b0, 32'h1000, 8'd1}) begin miscompares++; $display("FAIL t1_rd_a: got %h want %h", rd_q[0], {1'b0, 32'h1000, 8'd1}); end
        vectors++;
        if (rd_q[1] !== {1'b1, 32'h2000, 8'd2}) begin miscompares++; $display("FAIL t1_rd_b: got %h want %h", rd_q[1], {1'b1, 32'h2000, 8'd2}); end
        vectors++;
        if (start_cnt !== 1) begin miscompares++; $display("FAIL t1_start: got %0d want 1", start_cnt); end
        vectors++;
        if (wr_q.size() !== 8) begin miscompares++; $display("FAIL t1_wr_count: got %0d want 8", wr_q.size()); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (wr_q[i] !== exp_wr[i]) begin miscompares++; $display("FAIL t1_wr_addr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]); end
        end
        vectors++;
        if (err_q.size() !== 1 || err_q[0] !== 1'b0) begin miscompares++; $display("FAIL t1_done: count %0d err %b want 1/0", err_q.size(), err_q[0]); end
        vectors++;
        if ({busy, bus.cfg_ready} !== 2'b01) begin miscompares++; $display("FAIL t1_idle: busy/ready %b want 01", {busy, bus.cfg_ready}); end
    endtask

    task automatic test_multi_tile();
        int idx;
        logic [31:0] exp_a;
        clear_mon(); bus.rd_ready = 1'b1;
        start_job(16'd8, 16'd3, 16'd64, 32'h4000, 32'h8000, 32'hC000);
        @(posedge clk); #1;
        send_beats(31, 1);
        repeat (10) begin @(posedge clk); #1; end
        vectors++;
        if (err_q.size() !== 0) begin miscompares++; $display("FAIL t2_early_done: got %0d dones want 0", err_q.size()); end
        send_beats(1, 0);
        wait_done(200);
        vectors++;
        if (rd_q.size() !== 24) begin miscompares++; $display("FAIL t2_rd_count: got %0d want 24", rd_q.size()); end
        vectors++;
        if (rd_q[7] !== {1'b1, 32'h8040, 8'd2}) begin miscompares++; $display("FAIL t2_rd_tile01_b: got %h want %h", rd_q[7], {1'b1, 32'h8040, 8'd2}); end
        idx = 0;
        for (int ti = 0; ti < 8; ti += 4)
            for (int tj = 0; tj < 64; tj += 32)
                for (int k = 0; k < 3; k++) begin
                    exp_a = 32'h4000 + 32'((k * 8 + ti) * 2);
                    vectors++;
                    if (rd_q[idx] !== {1'b0, exp_a, 8'd1}) begin miscompares++; $display("FAIL t2_rd[%0d]: got %h want %h", idx, rd_q[idx], {1'b0, exp_a, 8'd1}); end
                    exp_a = 32'h8000 + 32'((k * 64 + tj) * 2);
                    vectors++;
                    if (rd_q[idx+1] !== {1'b1, exp_a, 8'd2}) begin miscompares++; $display("FAIL t2_rd[%0d]: got %h want %h", idx + 1, rd_q[idx+1], {1'b1, exp_a, 8'd2}); end
                    idx += 2;
                end
        idx = 0;
        for (int ti = 0; ti < 8; ti += 4)
            for (int tj = 0; tj < 64; tj += 32)
                for (int r = 0; r < 4; r++)
                    for (int bb = 0; bb < 2; bb++) begin
                        exp_a = 32'hC000 + 32'(((ti + r) * 64 + tj + bb * 16) * 2);
                        vectors++;
                        if (wr_q[idx] !== exp_a) begin miscompares++; $display("FAIL t2_wr[%0d]: got %h want %h", idx, wr_q[idx], exp_a); end
                        idx++;
                    end
        vectors++;
        if (err_q.size() !== 1 || done_cyc <= last_wr_cyc) begin miscompares++; $display("FAIL t2_done: count %0d done_cyc %0d last_wr %0d", err_q.size(), done_cyc, last_wr_cyc); end
    endtask

    task automatic test_backpressure();
        clear_mon(); bus.rd_ready = 1'b0;
        start_job(16'd4, 16'd1, 16'd32, 32'h1000, 32'h2000, 32'h3000);
        for (int i = 0; i < 20 && !bus.rd_valid; i++) begin @(posedge clk); #1; end
        bus.rd_ready = 1'b1; @(posedge clk); #1; bus.rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.rd_valid, bus.rd_sel, bus.rd_addr, bus.rd_beats} !== {2'b11, 32'h2000, 8'd2}) begin
                miscompares++;
                $display("FAIL t3_stall[%0d]: got %b/%b %h %0d want 1/1 2000 2", i, bus.rd_valid, bus.rd_sel, bus.rd_addr, bus.rd_beats);
            end
        end
        @(posedge clk); #1; bus.rd_ready = 1'b1;
        @(posedge clk); #1;
        send_beats(8, 0);
        wait_done(200);
        vectors++;
        if (rd_q.size() !== 2) begin miscompares++; $display("FAIL t3_rd_count: got %0d want 2", rd_q.size()); end
        vectors++;
        if (err_q.size() !== 1 || err_q[0] !== 1'b0) begin miscompares++; $display("FAIL t3_done: count %0d want 1 ok", err_q.size()); end
    endtask

    task automatic test_reject();
        logic [15:0] tm [3] = '{16'd6, 16'd4, 16'd4};
        logic [15:0] tn [3] = '{16'd1, 16'd0, 16'd1};
        logic [15:0] tp [3] = '{16'd32, 16'd32, 16'd48};
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            start_job(tm[i], tn[i], tp[i], 32'h1000, 32'h2000, 32'h3000);
            @(posedge clk); #1;
            vectors++;
            if ({done, err, busy} !== 3'b111) begin miscompares++; $display("FAIL t4_err[%0d]: done/err/busy %b want 111", i, {done, err, busy}); end
            @(posedge clk); #1;
            vectors++;
            if ({bus.cfg_ready, busy, done} !== 3'b100) begin miscompares++; $display("FAIL t4_idle[%0d]: ready/busy/done %b want 100", i, {bus.cfg_ready, busy, done}); end
            vectors++;
            if (rd_q.size() + start_cnt !== 0) begin miscompares++; $display("FAIL t4_quiet[%0d]: rd %0d starts %0d want 0", i, rd_q.size(), start_cnt); end
        end
    endtask

    task automatic test_reset_mid_job();
        clear_mon(); bus.rd_ready = 1'b1;
        start_job(16'd4, 16'd4, 16'd32, 32'h5000, 32'h6000, 32'h7000);
        for (int i = 0; i < 50 && rd_q.size() < 5; i++) @(negedge clk);
        vectors++;
        if (rd_q.size() < 5) begin miscompares++; $display("FAIL t5_reach_k2: got %0d reqs want 5", rd_q.size()); end
        @(posedge clk); #2; reset_n = 1'b0; #1;
        vectors++;
        if ({bus.cfg_ready, bus.rd_valid, array_start, busy, done, err} !== 6'b100000) begin
            miscompares++;
            $display("FAIL t5_reset_ctrl: got %b want 100000", {bus.cfg_ready, bus.rd_valid, array_start, busy, done, err});
        end
        vectors++;
        if ({bus.rd_addr, bus.wr_addr} !== 64'd0) begin miscompares++; $display("FAIL t5_reset_addr: %h %h want 0", bus.rd_addr, bus.wr_addr); end
        @(posedge clk); #1; reset_n = 1'b1;
        clear_mon();
        start_job(16'd4, 16'd1, 16'd32, 32'h1000, 32'h2000, 32'h3000);
        @(posedge clk); #1;
        send_beats(8, 0);
        wait_done(200);
        vectors++;
        if (rd_q[0] !== {1'b0, 32'h1000, 8'd1} || rd_q[1] !== {1'b1, 32'h2000, 8'd2}) begin
            miscompares++; $display("FAIL t5_restart_rd: got %h %h want k=0 tile 0", rd_q[0], rd_q[1]);
        end
        vectors++;
        if (wr_q[0] !== 32'h3000 || wr_q[7] !== 32'h30E0) begin miscompares++; $display("FAIL t5_restart_wr: got %h..%h want 3000..30e0", wr_q[0], wr_q[7]); end
        vectors++;
        if (err_q.size() !== 1) begin miscompares++; $display("FAIL t5_done: got %0d want 1", err_q.size()); end
    endtask

    task automatic test_interleave();
        int idx;
        logic [31:0] ea;
        clear_mon(); bus.rd_ready = 1'b0;
        start_job(16'd8, 16'd2, 16'd32, 32'h0100, 32'h0200, 32'h10000);
        fork
            begin
                for (int i = 0; i < 60; i++) begin bus.rd_ready = (i % 3 != 2); @(posedge clk); #1; end
                bus.rd_ready = 1'b1;
            end
            begin
                @(posedge clk); #1;
                send_beats(5, 0); repeat (3) begin @(posedge clk); #1; end
                send_beats(6, 2); send_beats(5, 0);
            end
        join
        wait_done(200);
        vectors++;
        if (rd_q.size() !== 8) begin miscompares++; $display("FAIL t6_rd_count: got %0d want 8", rd_q.size()); end
        idx = 0;
        for (int ti = 0; ti < 8; ti += 4)
            for (int k = 0; k < 2; k++) begin
                ea = 32'h0100 + 32'((k * 8 + ti) * 2);
                vectors++;
                if (rd_q[idx] !== {1'b0, ea, 8'd1}) begin miscompares++; $display("FAIL t6_rd[%0d]: got %h want %h", idx, rd_q[idx], {1'b0, ea, 8'd1}); end
                ea = 32'h0200 + 32'((k * 32) * 2);
                vectors++;
                if (rd_q[idx+1] !== {1'b1, ea, 8'd2}) begin miscompares++; $display("FAIL t6_rd[%0d]: got %h want %h", idx + 1, rd_q[idx+1], {1'b1, ea, 8'd2}); end
                idx += 2;
            end
        vectors++;
        if (wr_q.size() !== 16) begin miscompares++; $display("FAIL t6_wr_count: got %0d want 16", wr_q.size()); end
        idx = 0;
        for (int ti = 0; ti < 8; ti += 4)
            for (int r = 0; r < 4; r++)
                for (int bb = 0; bb < 2; bb++) begin
                    ea = 32'h10000 + 32'(((ti + r) * 32 + bb * 16) * 2);
                    vectors++;
                    if (wr_q[idx] !== ea) begin miscompares++; $display("FAIL t6_wr[%0d]: got %h want %h", idx, wr_q[idx], ea); end
                    idx++;
                end
        vectors++;
        if (err_q.size() !== 1 || done_cyc <= last_wr_cyc) begin miscompares++; $display("FAIL t6_done: count %0d done_cyc %0d last_wr %0d", err_q.size(), done_cyc, last_wr_cyc); end
    endtask

    initial begin
        bus.cfg_valid = 1'b0; bus.cfg_m = '0; bus.cfg_n = '0; bus.cfg_p = '0;
        bus.cfg_a = '0; bus.cfg_b = '0; bus.cfg_c = '0; bus.rd_ready = 1'b1;
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_backpressure();
        test_reject();
        test_reset_mid_job();
        test_interleave();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
